// File: rtl/shift_add_mult_4bit.sv
// shift_add_mult_4bit: sequential shift-and-add unsigned multiplier.
// Each CALC cycle handles one multiplier bit through a WIDTH-bit ripple-carry adder.
// The result is available as a 2*WIDTH-bit registered product.
// Optional feature: define MULT_EARLY_TERM_EN to enable early termination.
// With it, CALC ends as soon as the multiplier bits still to be processed are all zero.
module shift_add_mult_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int               CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, p_hi, p_lo;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   addend, sum;
    logic [WIDTH:0]     cy;
    logic [2*WIDTH-1:0] step_val, next_val;
    logic               last_step;

    // Ripple-carry adder: P_hi plus the multiplicand when the current multiplier bit is set.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        addend = p_lo[0] ? mcand : '0;
        cy     = '0;
        sum    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]  = p_hi[i] ^ addend[i] ^ cy[i];
            cy[i+1] = (p_hi[i] & addend[i]) | (cy[i] & (p_hi[i] ^ addend[i]));
        end
        // One step: {carry, sum, P_lo} shifted right by one.
        step_val = {cy[WIDTH], sum, p_lo[WIDTH-1:1]};
    end

`ifdef MULT_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic [CW-1:0]    rem_steps;
    logic             early;

    // Early exit: with count steps done, P_lo[WIDTH-1-count:0] holds the unprocessed multiplier bits.
    // When those bits are all zero, every remaining step is a plain shift.
    // In that case all the remaining shifts are applied at once.
    always_comb begin
        rem_mask  = {WIDTH{1'b1}} >> count;
        rem_steps = CW'(WIDTH) - count;
        early     = (p_lo & rem_mask) == '0;
        next_val  = early ? ({p_hi, p_lo} >> rem_steps) : step_val;
        last_step = early || (count == LAST);
    end
`else
    // Fixed-length CALC: exactly WIDTH steps.
    always_comb begin
        next_val  = step_val;
        last_step = (count == LAST);
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, per-step accumulate/shift, and the product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= A;
                        p_hi  <= '0;
                        p_lo  <= B;
                        count <= '0;
                    end
                end
                CALC: begin
                    {p_hi, p_lo} <= next_val;
                    count        <= count + CW'(1);
                    // The product is written as DONE is entered.
                    // It is therefore already valid during the cycle done is high.
                    if (last_step) product <= next_val;
                end
                default: ;
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_shift_add_mult_4bit.sv
// tb_shift_add_mult_4bit: scoreboard bench for shift_add_mult_4bit (WIDTH=4).
// The driver queues the expected product and latency for each operation.
// The monitor pops and checks an entry on every cycle done is high.
module tb_shift_add_mult_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A, B;
    logic [7:0] product;
    logic       busy, done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [7:0] prod;
        int         e0;
        int         lat;
    } exp_t;

    exp_t sb[$];

    shift_add_mult_4bit #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of CALC edges: 4, or earlier when the remaining multiplier bits are zero.
    function automatic int exp_lat(input logic [3:0] b);
`ifdef MULT_EARLY_TERM_EN
        for (int k = 1; k <= 4; k++)
            if ((b >> (k - 1)) == 4'd0) return k;
`endif
        return 4;
    endfunction

    // Monitor: every cycle with done high must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", {24'd0, product}, {24'd0, e.prod});
                check("done_latency", cyc - e.e0, e.lat);
                check("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Present operands with start, wait for the accepting edge E0, then optionally queue the expected result.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit push,
                         input bit junk, output int e0);
        exp_t e;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        if (push) begin
            e.prod = 8'(a * b);
            e.e0   = e0;
            e.lat  = exp_lat(b);
            sb.push_back(e);
        end
        if (junk) begin
            A = 4'd15; B = 4'd15; start = 1'b1;
        end else begin
            A = 4'($urandom); B = 4'($urandom); start = 1'b0;
        end
    endtask

    // Walk busy/done cycle by cycle from E0 to one cycle past the done pulse.
    task automatic timing_check(input int lat);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", i), {31'd0, busy}, {31'd0, (i < lat)});
            check($sformatf("done_c%0d", i), {31'd0, done}, {31'd0, (i == lat)});
        end
        @(negedge clk);
        check("done_after_pulse", {31'd0, done}, 32'd0);
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        int e0;
        int l1, l2;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("reset_product", {24'd0, product}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // 15*15: full-length run with a carry out of the adder.
        issue(4'd15, 4'd15, 1'b1, 1'b0, e0);
        timing_check(exp_lat(4'd15));
        wait_idle();

        // 9*0: zero multiplier, early exit when the option is built in.
        issue(4'd9, 4'd0, 1'b1, 1'b0, e0);
        timing_check(exp_lat(4'd0));
        wait_idle();

        // 6*5 with operands and start disturbed during CALC: one result, 30.
        issue(4'd6, 4'd5, 1'b1, 1'b1, e0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // start held high: (3,4) then (7,2); the second start is accepted the edge after done drops.
        @(negedge clk);
        A = 4'd3; B = 4'd4; start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        l1 = exp_lat(4'd4);
        l2 = exp_lat(4'd2);
        sb.push_back('{prod: 8'd12, e0: e0, lat: l1});
        sb.push_back('{prod: 8'd14, e0: e0 + l1 + 2, lat: l2});
        A = 4'd7; B = 4'd2;
        repeat (l1 + 2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // 13*11 aborted by reset after E2: no done, outputs cleared at once.
        issue(4'd13, 4'd11, 1'b0, 1'b0, e0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_product", {24'd0, product}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'd2, 4'd3, 1'b1, 1'b0, e0);
        timing_check(exp_lat(4'd3));
        wait_idle();

        // All 256 operand pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(4'(a), 4'(b), 1'b1, 1'b0, e0);
                wait_idle();
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
